// File: rtl/demux1x2_fifo.sv
// demux1x2_fifo: steers a valid-qualified word stream into one of two
// lane FIFOs, chosen by selector. Each lane drains through its own registered
// pop/valid output port.

// One lane: a DEPTH-entry circular FIFO with a registered read port and a
// sticky overflow flag.
module demux_lane_fifo #(
   parameter int WIDTH = 2,
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic             clk,
   input  logic             reset_L,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   output logic             valid_out,
   output logic             full,
   output logic             empty,
   output logic             overflow
);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr, wr_ptr;
   logic [AW:0]      count;
   logic             do_pop, do_push;

   // A pop needs a stored word. A push is accepted unless the lane is full,
   // and a same-cycle pop on a full lane frees the slot it needs.
   assign do_pop  = pop && (count != '0);
   assign do_push = push && ((count != FULL_CNT) || do_pop);

   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);

   // Storage needs no reset; stale entries are never read because count gates every pop.
   always_ff @(posedge clk) begin
      if (reset_L && do_push) mem[wr_ptr] <= data_in;
   end

   // Pointers, occupancy, registered read port and sticky overflow.
   always_ff @(posedge clk) begin
      if (!reset_L) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
         data_out  <= '0;
         valid_out <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         valid_out <= do_pop;
         if (do_pop) begin
            data_out <= mem[rd_ptr];
            rd_ptr   <= rd_ptr + AW'(1);
         end
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
         if (push && !do_push) overflow <= 1'b1;
      end
   end
endmodule

module demux1x2_fifo #(
   parameter int WIDTH = 2,
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic             clk,
   input  logic             reset_L,
   input  logic             selector,
   input  logic             valid_in,
   input  logic [WIDTH-1:0] data_in,
   input  logic             pop_0,
   input  logic             pop_1,
   output logic [WIDTH-1:0] data_out0,
   output logic [WIDTH-1:0] data_out1,
   output logic             valid_out0,
   output logic             valid_out1,
   output logic             full_0,
   output logic             full_1,
   output logic             empty_0,
   output logic             empty_1,
   output logic             overflow_0,
   output logic             overflow_1
);
   localparam int NUM_LANES = 2;

   logic [NUM_LANES-1:0]            push, pop, valid_v, full_v, empty_v, ovf_v;
   logic [NUM_LANES-1:0][WIDTH-1:0] dout_v;

   // Only the selected lane sees the push; valid_in low gates out the selector.
   assign push = {valid_in & selector, valid_in & ~selector};
   assign pop  = {pop_1, pop_0};

   for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      demux_lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_lane (
         .clk       (clk),
         .reset_L   (reset_L),
         .push      (push[l]),
         .pop       (pop[l]),
         .data_in   (data_in),
         .data_out  (dout_v[l]),
         .valid_out (valid_v[l]),
         .full      (full_v[l]),
         .empty     (empty_v[l]),
         .overflow  (ovf_v[l])
      );
   end

   assign data_out0  = dout_v[0];
   assign data_out1  = dout_v[1];
   assign valid_out0 = valid_v[0];
   assign valid_out1 = valid_v[1];
   assign full_0     = full_v[0];
   assign full_1     = full_v[1];
   assign empty_0    = empty_v[0];
   assign empty_1    = empty_v[1];
   assign overflow_0 = ovf_v[0];
   assign overflow_1 = ovf_v[1];
endmodule

// File: tb/tb_demux1x2_fifo.sv
// Bench for demux1x2_fifo: queue scoreboard per lane, one task per scenario.
module tb_demux1x2_fifo;
   localparam int WIDTH = 2;
   localparam int DEPTH = 4;

   logic             clk = 1'b0;
   logic             reset_L, selector, valid_in, pop_0, pop_1;
   logic [WIDTH-1:0] data_in;
   logic [WIDTH-1:0] data_out0, data_out1;
   logic             valid_out0, valid_out1, full_0, full_1, empty_0, empty_1;
   logic             overflow_0, overflow_1;

   int errors = 0;
   int checks = 0;

   logic [WIDTH-1:0] q0[$];
   logic [WIDTH-1:0] q1[$];
   logic             ovf_m0, ovf_m1;
   logic [WIDTH-1:0] exp_d;

   demux1x2_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(2)) dut (
      .clk(clk), .reset_L(reset_L), .selector(selector), .valid_in(valid_in),
      .data_in(data_in), .pop_0(pop_0), .pop_1(pop_1),
      .data_out0(data_out0), .data_out1(data_out1),
      .valid_out0(valid_out0), .valid_out1(valid_out1),
      .full_0(full_0), .full_1(full_1), .empty_0(empty_0), .empty_1(empty_1),
      .overflow_0(overflow_0), .overflow_1(overflow_1)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach summary, errors=%0d", errors);
      $fatal(1);
   end

   // Drive one cycle and update the scoreboard with accepted pushes.
   // Popped words stay queued; the calling test pops and compares them.
   task automatic cyc(input logic rst_n, input logic sel, input logic vin,
                      input logic [WIDTH-1:0] din, input logic p0, input logic p1);
      bit pok;
      @(negedge clk);
      reset_L = rst_n; selector = sel; valid_in = vin; data_in = din;
      pop_0 = p0; pop_1 = p1;
      if (!rst_n) begin
         q0.delete(); q1.delete(); ovf_m0 = 1'b0; ovf_m1 = 1'b0;
      end else if (vin) begin
         if (!sel) begin
            pok = p0 && (q0.size() > 0);
            if (q0.size() < DEPTH || pok) q0.push_back(din); else ovf_m0 = 1'b1;
         end else begin
            pok = p1 && (q1.size() > 0);
            if (q1.size() < DEPTH || pok) q1.push_back(din); else ovf_m1 = 1'b1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++)
         cyc(1'b0, 1'($urandom_range(0,1)), 1'($urandom_range(0,1)),
             2'($urandom_range(0,3)), 1'($urandom_range(0,1)), 1'($urandom_range(0,1)));
      checks++;
      if ({data_out0, data_out1} !== '0) begin
         errors++; $display("FAIL reset_data: got %h %h want 0 0", data_out0, data_out1);
      end
      checks++;
      if ({valid_out0, valid_out1} !== 2'b00) begin
         errors++; $display("FAIL reset_valid: got %b%b want 00", valid_out0, valid_out1);
      end
      checks++;
      if ({empty_0, empty_1, full_0, full_1, overflow_0, overflow_1} !== 6'b110000) begin
         errors++; $display("FAIL reset_flags: got e%b%b f%b%b o%b%b want e11 f00 o00",
                            empty_0, empty_1, full_0, full_1, overflow_0, overflow_1);
      end
   endtask

   task automatic test_steering();
      cyc(1, 0, 1, 2'b01, 0, 0);
      cyc(1, 1, 1, 2'b10, 0, 0);
      cyc(1, 0, 1, 2'b11, 0, 0);
      checks++;
      if (empty_0 !== 1'b0 || empty_1 !== 1'b0) begin
         errors++; $display("FAIL steer_fill: got empty %b%b want 00", empty_0, empty_1);
      end
      for (int i = 0; i < 2; i++) begin
         cyc(1, 0, 0, 0, 1, 0);
         exp_d = q0.pop_front();
         checks++;
         if (valid_out0 !== 1'b1 || data_out0 !== exp_d || valid_out1 !== 1'b0) begin
            errors++; $display("FAIL steer_lane0_pop%0d: got v%b d%b v1=%b want v1 d%b v1=0",
                               i, valid_out0, data_out0, valid_out1, exp_d);
         end
      end
      cyc(1, 0, 0, 0, 0, 1);
      exp_d = q1.pop_front();
      checks++;
      if (valid_out1 !== 1'b1 || data_out1 !== exp_d || valid_out0 !== 1'b0) begin
         errors++; $display("FAIL steer_lane1_pop: got v%b d%b v0=%b want v1 d%b v0=0",
                            valid_out1, data_out1, valid_out0, exp_d);
      end
      cyc(1, 0, 0, 0, 0, 0);
      checks++;
      if (valid_out1 !== 1'b0 || data_out1 !== 2'b10 || empty_0 !== 1'b1 || empty_1 !== 1'b1) begin
         errors++; $display("FAIL steer_pulse: got v1=%b d1=%b e%b%b want v1=0 d1=10 e11",
                            valid_out1, data_out1, empty_0, empty_1);
      end
   endtask

   task automatic test_full_overflow();
      for (int i = 0; i < 4; i++) cyc(1, 0, 1, 2'(i), 0, 0);
      checks++;
      if (full_0 !== 1'b1 || overflow_0 !== 1'b0) begin
         errors++; $display("FAIL full_after4: got full=%b ovf=%b want 1 0", full_0, overflow_0);
      end
      cyc(1, 0, 1, 2'd0, 0, 0);
      checks++;
      if (overflow_0 !== ovf_m0 || ovf_m0 !== 1'b1 || full_0 !== 1'b1 || overflow_1 !== 1'b0) begin
         errors++; $display("FAIL overflow_after5: got ovf0=%b full0=%b ovf1=%b want 1 1 0",
                            overflow_0, full_0, overflow_1);
      end
      for (int i = 0; i < 4; i++) begin
         cyc(1, 0, 0, 0, 1, 0);
         exp_d = q0.pop_front();
         checks++;
         if (valid_out0 !== 1'b1 || data_out0 !== exp_d) begin
            errors++; $display("FAIL ovf_drain%0d: got v%b d%0d want v1 d%0d",
                               i, valid_out0, data_out0, exp_d);
         end
      end
      checks++;
      if (empty_0 !== 1'b1 || overflow_0 !== 1'b1) begin
         errors++; $display("FAIL ovf_empty_sticky: got empty=%b ovf=%b want 1 1", empty_0, overflow_0);
      end
      // Empty pop is ignored and data_out0 holds the last word.
      cyc(1, 0, 0, 0, 1, 0);
      checks++;
      if (valid_out0 !== 1'b0 || data_out0 !== 2'd3) begin
         errors++; $display("FAIL empty_pop_hold: got v%b d%0d want v0 d3", valid_out0, data_out0);
      end
   endtask

   task automatic test_simul_full();
      for (int i = 0; i < 4; i++) cyc(1, 1, 1, 2'(i), 0, 0);
      cyc(1, 1, 1, 2'b10, 0, 1);
      exp_d = q1.pop_front();
      checks++;
      if (valid_out1 !== 1'b1 || data_out1 !== exp_d || exp_d !== 2'd0) begin
         errors++; $display("FAIL simul_full_pop: got v%b d%0d want v1 d0", valid_out1, data_out1);
      end
      checks++;
      if (full_1 !== 1'b1 || overflow_1 !== 1'b0 || overflow_1 !== ovf_m1) begin
         errors++; $display("FAIL simul_full_flags: got full=%b ovf=%b want 1 0", full_1, overflow_1);
      end
      for (int i = 0; i < 4; i++) begin
         cyc(1, 0, 0, 0, 0, 1);
         exp_d = q1.pop_front();
         checks++;
         if (valid_out1 !== 1'b1 || data_out1 !== exp_d) begin
            errors++; $display("FAIL simul_full_drain%0d: got v%b d%0d want v1 d%0d",
                               i, valid_out1, data_out1, exp_d);
         end
      end
      checks++;
      if (empty_1 !== 1'b1) begin
         errors++; $display("FAIL simul_full_empty: got %b want 1", empty_1);
      end
   endtask

   task automatic test_empty_corner();
      cyc(1, 0, 1, 2'b11, 1, 0);
      checks++;
      if (valid_out0 !== 1'b0 || empty_0 !== 1'b0) begin
         errors++; $display("FAIL empty_corner: got v%b empty=%b want v0 empty=0", valid_out0, empty_0);
      end
      cyc(1, 0, 0, 0, 1, 0);
      exp_d = q0.pop_front();
      checks++;
      if (valid_out0 !== 1'b1 || data_out0 !== exp_d || exp_d !== 2'b11) begin
         errors++; $display("FAIL empty_corner_next: got v%b d%b want v1 d11", valid_out0, data_out0);
      end
   endtask

   // Lane 0 push overlapping lane 1 pop, then overlapping push/pop on lane 0.
   task automatic test_back_to_back();
      cyc(1, 1, 1, 2'b01, 0, 0);
      cyc(1, 0, 1, 2'b10, 0, 1);
      exp_d = q1.pop_front();
      checks++;
      if (valid_out1 !== 1'b1 || data_out1 !== exp_d || empty_0 !== 1'b0 || valid_out0 !== 1'b0) begin
         errors++; $display("FAIL lane_indep: got v1=%b d1=%b e0=%b v0=%b want 1 %b 0 0",
                            valid_out1, data_out1, empty_0, valid_out0, exp_d);
      end
      // Wrap: 10 words through lane 0 with a pop every cycle after the first push.
      for (int i = 0; i < 10; i++) begin
         cyc(1, 0, 1, 2'($urandom_range(0,3)), 1, 0);
         exp_d = q0.pop_front();
         checks++;
         if (valid_out0 !== 1'b1 || data_out0 !== exp_d) begin
            errors++; $display("FAIL wrap%0d: got v%b d%b want v1 d%b", i, valid_out0, data_out0, exp_d);
         end
      end
      cyc(1, 0, 0, 0, 1, 0);
      exp_d = q0.pop_front();
      checks++;
      if (valid_out0 !== 1'b1 || data_out0 !== exp_d || empty_0 !== 1'b1) begin
         errors++; $display("FAIL wrap_last: got v%b d%b e%b want v1 d%b e1",
                            valid_out0, data_out0, empty_0, exp_d);
      end
      // Reset with two words queued discards them.
      cyc(1, 0, 1, 2'b01, 0, 0);
      cyc(1, 0, 1, 2'b10, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
      checks++;
      if (empty_0 !== 1'b1 || data_out0 !== '0 || valid_out0 !== 1'b0 || overflow_0 !== 1'b0) begin
         errors++; $display("FAIL wrap_reset: got e%b d%b v%b o%b want e1 d00 v0 o0",
                            empty_0, data_out0, valid_out0, overflow_0);
      end
      cyc(1, 0, 0, 0, 1, 0);
      checks++;
      if (valid_out0 !== 1'b0 || empty_0 !== 1'b1) begin
         errors++; $display("FAIL post_reset_pop: got v%b e%b want v0 e1", valid_out0, empty_0);
      end
   endtask

   initial begin
      reset_L = 1'b0; selector = 1'b0; valid_in = 1'b0; data_in = '0;
      pop_0 = 1'b0; pop_1 = 1'b0; ovf_m0 = 1'b0; ovf_m1 = 1'b0;
      test_reset();
      test_steering();
      test_full_overflow();
      cyc(0, 0, 0, 0, 0, 0);
      test_simul_full();
      test_empty_corner();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
